// File: rtl/gate_demo_pkg.sv
// Shared gate-select codes, sequencer state encoding and the reference
// gate function used by the board truth-table demos.
package gate_demo_pkg;

  localparam logic [2:0] SEL_OR   = 3'b000;
  localparam logic [2:0] SEL_AND  = 3'b001;
  localparam logic [2:0] SEL_XOR  = 3'b010;
  localparam logic [2:0] SEL_NOR  = 3'b011;
  localparam logic [2:0] SEL_NAND = 3'b100;
  localparam logic [2:0] SEL_XNOR = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRIVE     = 3'd1,
    ST_SAMPLE    = 3'd2,
    ST_WAIT_STEP = 3'd3,
    ST_VERDICT   = 3'd4
  } state_t;

  // Codes 11x are reserved: a sweep still runs but never yields a verdict.
  function automatic logic sel_valid(input logic [2:0] sel);
    return sel[2:1] != 2'b11;
  endfunction

  function automatic logic expected(input logic [2:0] sel, input logic a, input logic b);
    logic y;
    case (sel)
      SEL_OR:   y = a | b;
      SEL_AND:  y = a & b;
      SEL_XOR:  y = a ^ b;
      SEL_NOR:  y = ~(a | b);
      SEL_NAND: y = ~(a & b);
      SEL_XNOR: y = ~(a ^ b);
      default:  y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a bouncing push-button, accepts a level change only after it is
// stable for DEBOUNCE_TICKS cycles, and emits a registered 1-cycle rising pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_TICKS = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;
  logic          level_q, rise_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // Any return to the accepted level restarts the stability count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        rise_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Walks a two-input gate through rows 00..11 on manual or timed steps, samples
// its output after a settle time and reports PASS/FAIL against the selected function.
module gate_truth_table_sequencer
  import gate_demo_pkg::*;
#(
  parameter int unsigned STEP_TICKS     = 100_000_000,
  parameter int unsigned DEBOUNCE_TICKS = 1_000_000,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic       I_P_CLK,
  input  logic       I_P_RST,
  input  logic       I_P_MODE,
  input  logic       I_P_STEP,
  input  logic [2:0] I_P_GATE_SEL,
  input  logic       I_P_GATE_Y,
  output logic       O_P_GATE_A,
  output logic       O_P_GATE_B,
  output logic       O_P_LED_A,
  output logic       O_P_LED_B,
  output logic       O_P_LED_Y,
  output logic [1:0] O_P_ROW,
  output logic       O_P_LED_PASS,
  output logic       O_P_LED_FAIL
);

  localparam int TW = $clog2(STEP_TICKS);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  logic          mode_s1_q, mode_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic          step_rise, step_lvl_unused;
  logic          step_ev;

  state_t        state_q;
  logic [1:0]    row_q;
  logic [SW-1:0] settle_q;
  logic [2:0]    sel_q;
  logic          mism_q, mism_d;
  logic          led_y_q, pass_q, fail_q;

  button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_step_db (
    .clk_i   (I_P_CLK),
    .rst_i   (I_P_RST),
    .btn_i   (I_P_STEP),
    .level_o (step_lvl_unused),
    .rise_o  (step_rise)
  );

  always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
    if (I_P_RST) begin
      mode_s1_q  <= 1'b0;
      mode_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      mode_s1_q <= I_P_MODE;
      mode_q    <= mode_s1_q;
      if (!mode_q || tick) tick_cnt_q <= '0;
      else                 tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign tick    = mode_q && (tick_cnt_q == TW'(STEP_TICKS - 1));
  assign step_ev = mode_q ? tick : step_rise;

  assign mism_d = mism_q |
                  (sel_valid(sel_q) & (I_P_GATE_Y != expected(sel_q, row_q[1], row_q[0])));

  always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
    if (I_P_RST) begin
      state_q  <= ST_IDLE;
      row_q    <= 2'd0;
      settle_q <= '0;
      sel_q    <= 3'b000;
      mism_q   <= 1'b0;
      led_y_q  <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_VERDICT: begin
          if (step_ev) begin
            state_q  <= ST_DRIVE;
            row_q    <= 2'd0;
            settle_q <= '0;
            sel_q    <= I_P_GATE_SEL;
            mism_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) state_q  <= ST_SAMPLE;
          else                                    settle_q <= settle_q + 1'b1;
        end
        ST_SAMPLE: begin
          led_y_q <= I_P_GATE_Y;
          mism_q  <= mism_d;
          if (row_q == 2'd3) begin
            state_q <= ST_VERDICT;
            pass_q  <= sel_valid(sel_q) & ~mism_d;
            fail_q  <= sel_valid(sel_q) & mism_d;
          end else begin
            state_q <= ST_WAIT_STEP;
          end
        end
        ST_WAIT_STEP: begin
          if (step_ev) begin
            state_q  <= ST_DRIVE;
            row_q    <= row_q + 2'd1;
            settle_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operands are the row bits directly, so they change on the DRIVE-entry edge.
  assign O_P_GATE_A   = row_q[1];
  assign O_P_GATE_B   = row_q[0];
  assign O_P_LED_A    = row_q[1];
  assign O_P_LED_B    = row_q[0];
  assign O_P_LED_Y    = led_y_q;
  assign O_P_ROW      = row_q;
  assign O_P_LED_PASS = pass_q;
  assign O_P_LED_FAIL = fail_q;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Scoreboard bench: stimulus pushes the ordered sequence of output snapshots the
// sequencer must show; a monitor pops one on every visible output change.
module tb_gate_truth_table_sequencer;

  localparam int DEB = 4;
  localparam int STP = 16;
  localparam int SET = 2;

  logic       clk, rst, mode, step, gate_y;
  logic [2:0] sel;
  logic       ga, gb, la, lb, ly, pass, fail;
  logic [1:0] row;
  int         g_fn;
  int         errs = 0;
  int         checks = 0;

  typedef struct packed {
    logic [1:0] row;
    logic a, b, la, lb, y, pass, fail;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dly;
  } exp_t;

  exp_t  sb[$];
  snap_t cur_snap;

  // Reference model: only the stable points between steps are tracked.
  int         m_st;  // 0 idle, 1 waiting for next row, 2 verdict shown
  logic [1:0] m_row;
  logic [2:0] m_sel;
  logic       m_mism, m_y, m_pass, m_fail;
  snap_t      m_last;

  gate_truth_table_sequencer #(
    .STEP_TICKS(STP), .DEBOUNCE_TICKS(DEB), .SETTLE_CYCLES(SET)
  ) dut (
    .I_P_CLK(clk), .I_P_RST(rst), .I_P_MODE(mode), .I_P_STEP(step),
    .I_P_GATE_SEL(sel), .I_P_GATE_Y(gate_y),
    .O_P_GATE_A(ga), .O_P_GATE_B(gb), .O_P_LED_A(la), .O_P_LED_B(lb),
    .O_P_LED_Y(ly), .O_P_ROW(row), .O_P_LED_PASS(pass), .O_P_LED_FAIL(fail)
  );

  function automatic logic ref_fn(input int f, input logic a, input logic b);
    int s;
    s = int'(a) + int'(b);
    case (f)
      0: return s > 0;
      1: return s == 2;
      2: return s == 1;
      3: return s == 0;
      4: return s < 2;
      5: return s != 1;
      default: return 1'b0;
    endcase
  endfunction

  assign gate_y   = ref_fn(g_fn, ga, gb);
  assign cur_snap = {row, ga, gb, la, lb, ly, pass, fail};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic snap_t mk();
    return {m_row, m_row[1], m_row[0], m_row[1], m_row[0], m_y, m_pass, m_fail};
  endfunction

  task automatic push(input snap_t s, input int d);
    exp_t e;
    e.s   = s;
    e.dly = d;
    sb.push_back(e);
  endtask

  // One step event as seen from the stable state the model is in.
  task automatic model_step(input bit do_sample);
    snap_t s1, s2;
    bit    p1;
    logic  a, b, y;
    if (m_st != 1) begin
      m_row = 2'd0; m_sel = sel; m_mism = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
    end else begin
      m_row = m_row + 2'd1;
    end
    a  = m_row[1];
    b  = m_row[0];
    s1 = mk();
    p1 = (s1 != m_last);
    if (p1) push(s1, 0);
    m_last = s1;
    if (!do_sample) return;
    y = ref_fn(g_fn, a, b);
    if (m_sel < 3'd6 && y != ref_fn(int'(m_sel), a, b)) m_mism = 1'b1;
    m_y = y;
    if (m_row == 2'd3) begin
      m_st = 2; m_pass = (m_sel < 3'd6) & ~m_mism; m_fail = (m_sel < 3'd6) & m_mism;
    end else begin
      m_st = 1;
    end
    s2 = mk();
    if (s2 != s1) push(s2, p1 ? SET + 1 : 0);
    m_last = s2;
  endtask

  task automatic press(input int hi, input int lo);
    step = 1'b1;
    repeat (hi) @(negedge clk);
    step = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic step_press(input int hi, input int lo);
    model_step(1'b1);
    press(hi, lo);
  endtask

  initial begin : monitor
    snap_t last;
    exp_t  e;
    int    since, n;
    last = '0; since = 0; n = 0;
    forever begin
      @(negedge clk);
      since++;
      if (cur_snap !== last) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_change actual=0x%0h required=0x%0h", cur_snap, last);
        end else begin
          e = sb.pop_front();
          chk($sformatf("snap%0d", n), int'(cur_snap), int'(e.s));
          if (e.dly > 0) chk($sformatf("y_latency%0d", n), since, e.dly);
        end
        n++;
        last  = cur_snap;
        since = 0;
      end
    end
  end

  initial begin : stim
    bit seen;
    clk_init: begin
      rst = 1'b0; mode = 1'b0; step = 1'b0; sel = 3'b000; g_fn = 0;
      m_st = 0; m_row = 2'd0; m_sel = 3'b000; m_mism = 1'b0;
      m_y = 1'b0; m_pass = 1'b0; m_fail = 1'b0; m_last = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(cur_snap), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Manual OR sweep against an OR gate, then AND expected against the same gate.
    sel = 3'b000; g_fn = 0;
    repeat (4) step_press(8, 10);
    sel = 3'b001;
    repeat (4) step_press(8, 10);

    // Bouncing press inside a sweep advances exactly one row.
    step_press(8, 10);
    model_step(1'b1);
    for (int i = 0; i < 12; i++) begin
      step = ((i % 4) < 2);
      @(negedge clk);
    end
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    repeat (14) @(negedge clk);
    repeat (2) step_press(8, 10);

    // New sweep; short re-press while operands settle must be ignored.
    model_step(1'b1);
    step = 1'b1; repeat (8) @(negedge clk);
    step = 1'b0; repeat (1) @(negedge clk);
    step = 1'b1; repeat (2) @(negedge clk);
    step = 1'b0; repeat (14) @(negedge clk);

    // Auto mode: four timer steps, button ignored, then stop in WAIT_STEP.
    repeat (4) model_step(1'b1);
    mode = 1'b1;
    press(8, 10);
    press(8, 10);
    repeat (STP * 4 + 8 - 36) @(negedge clk);
    mode = 1'b0;
    repeat (40) @(negedge clk);

    // Reset while driving row 2.
    step_press(8, 10);
    model_step(1'b0);
    step = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (row == 2'd2) seen = 1'b1;
    end
    chk("row2_reached", int'(seen), 1);
    @(posedge clk);
    #1;
    push('0, 0);
    rst = 1'b1; step = 1'b0;
    #1 chk("reset_immediate", int'(cur_snap), 0);
    m_st = 0; m_row = 2'd0; m_mism = 1'b0; m_y = 1'b0;
    m_pass = 1'b0; m_fail = 1'b0; m_last = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reserved selection; a mid-sweep change to OR must not produce a verdict.
    sel = 3'b111; g_fn = 0;
    step_press(8, 10);
    sel = 3'b000;
    repeat (3) step_press(8, 10);

    // Randomised sweeps: random selection against a matching or random gate.
    repeat (6) begin
      sel  = 3'($urandom_range(0, 7));
      g_fn = ($urandom_range(0, 1) == 1) ? ((sel < 3'd6) ? int'(sel) : 0)
                                         : int'($urandom_range(0, 5));
      repeat (4) step_press(int'($urandom_range(6, 10)), int'($urandom_range(10, 14)));
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_sequencer.md
Name: gate_truth_table_sequencer

Overview:
Self-test controller for the two-input gate demonstrations on the BASYS 3 board. Drives the operands of a gate under test through all four input rows (00, 01, 10, 11) and samples the gate output. Compares each sample against the expected function chosen on switches, then shows the row, operands, result and a PASS/FAIL verdict on LEDs. Rows advance on a debounced push-button (manual) or on a periodic timer (auto).

Parameters:
STEP_TICKS, 100_000_000, clock cycles between auto-mode steps (1 s at 100 MHz); minimum 2.
DEBOUNCE_TICKS, 1_000_000, cycles the step button must be stable before a level change is accepted (10 ms); minimum 1.
SETTLE_CYCLES, 4, cycles operands are held before the gate output is sampled; minimum 1.

Ports:
I_P_CLK  in  1  system clock, 100 MHz.
I_P_RST  in  1  asynchronous, active-high reset.
I_P_MODE  in  1  0 = manual step, 1 = auto step; switch input, asynchronous.
I_P_STEP  in  1  raw step push-button; asynchronous and bouncing.
I_P_GATE_SEL  in  3  expected function: 000 OR, 001 AND, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 11x reserved.
I_P_GATE_Y  in  1  output of the gate under test.
O_P_GATE_A  out  1  operand A to the gate; equals row[1].
O_P_GATE_B  out  1  operand B to the gate; equals row[0].
O_P_LED_A  out  1  mirror of O_P_GATE_A.
O_P_LED_B  out  1  mirror of O_P_GATE_B.
O_P_LED_Y  out  1  last sampled gate output.
O_P_ROW  out  2  current row index.
O_P_LED_PASS  out  1  sweep finished with no mismatch and a valid selection.
O_P_LED_FAIL  out  1  sweep finished with at least one mismatch and a valid selection.

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; row = 0.
  - All outputs 0; mismatch flag cleared.
  - Debouncer and tick counter cleared.
- Input conditioning:
  - I_P_MODE passes through a 2-FF synchroniser.
  - I_P_STEP passes through a 2-FF synchroniser, then the debouncer, then a rising-edge detector, giving a 1-cycle step pulse.
- Auto tick:
  - Counter runs only while synchronised MODE = 1; it is held at 0 while MODE = 0.
  - Pulses one cycle when the count reaches STEP_TICKS-1, then wraps to 0.
- Step event definition:
  - MODE = 0: the debounced step pulse.
  - MODE = 1: the tick pulse; the button is ignored.
- State machine:
  - IDLE: on a step event → DRIVE with row = 0; latch I_P_GATE_SEL into sel_q; clear mismatch.
  - DRIVE: O_P_GATE_A/B = row bits, updated in the cycle DRIVE is entered. Hold for SETTLE_CYCLES cycles, then → SAMPLE.
  - SAMPLE (1 cycle):
    - O_P_LED_Y <= I_P_GATE_Y.
    - If sel_q is valid and I_P_GATE_Y ≠ expected(sel_q, A, B), set mismatch (sticky for the sweep).
    - Then → VERDICT if row == 3, else → WAIT_STEP.
  - WAIT_STEP: on a step event, row <= row+1 → DRIVE.
  - VERDICT:
    - PASS = valid & ~mismatch; FAIL = valid & mismatch; both are registered and held.
    - On a step event: clear PASS/FAIL; row = 0; re-latch sel_q; clear mismatch → DRIVE (new sweep).
- Timing:
  - Step pulse at cycle t → DRIVE and new operands at t+1.
  - SAMPLE at t+1+SETTLE_CYCLES; O_P_LED_Y valid at t+2+SETTLE_CYCLES.
- Step events in DRIVE or SAMPLE are dropped, never queued.
- I_P_GATE_SEL changes mid-sweep have no effect until the next sweep start.
- Reserved sel (11x): the sweep runs normally; PASS = FAIL = 0.
- MODE change mid-sweep: takes effect for the next step event; the current row completes.
- Row never wraps mid-sweep; wrap to 0 happens only from VERDICT.

Decomposition:
- Shared package gate_demo_pkg holds:
  - GATE_SEL code constants (OR..XNOR, reserved).
  - FSM state encodings: IDLE, DRIVE, SAMPLE, WAIT_STEP, VERDICT.
  - Expected-value function expected(sel, a, b).
- Sub-module button_debouncer (parameter DEBOUNCE_TICKS):
  - Contains the synchroniser and stable-count filter.
  - Outputs the debounced level and a rising-edge pulse.
  - Reused by later board demos.

Test Plan (DEBOUNCE_TICKS=4, STEP_TICKS=16, SETTLE_CYCLES=2; bench models the gate under test):
1. Manual, sel=000, bench Y = A|B; 4 clean presses → (A,B) = 00,01,10,11; LED_Y = 0,1,1,1; after the 4th SAMPLE, PASS=1, FAIL=0; 5th press → PASS cleared, row=0.
2. Manual, sel=001, bench Y = A|B; full sweep → FAIL=1, PASS=0. Mismatch set at rows 1 and 2 and held through row 3.
3. Bounce: STEP toggles every 2 cycles for 12 cycles, then stays high for 10 → exactly one row advance; O_P_ROW increments by 1.
4. Auto: MODE=1 → rows advance every 16 cycles. Button presses → no effect. MODE=0 mid-sweep → advancing stops in WAIT_STEP.
5. Timing/drop: press at cycle t → A/B change at t+1, LED_Y at t+4. A second press during DRIVE → ignored, row unchanged.
6. Reset asserted in DRIVE row 2 → all outputs 0 immediately, before the next clock edge. After release, sel=111 sweep completes with PASS=FAIL=0. Changing sel to 000 mid-sweep → verdict still 0/0.
